des_pipe_ctrl: RTL and testbench
================================

# des_pipe_ctrl

Sequencer for the 16-round DES/TDES pipeline datapath, which has no stall or valid signalling of its own. Accepts 64-bit blocks over valid/ready, launches them into the pipeline, tracks in-flight blocks with a valid shift register, and captures results into an output FIFO. Credit-based throttling keeps the free-running pipeline from overrunning the FIFO. Key changes are sequenced by draining the pipeline before a new key is applied, because the key schedule is shared by all stages.

## Interface
- PIPE_LAT, 17, cycles from a `pipe_data` update to the matching `pipe_ret`; minimum 1.
- KEY_LAT, 1, cycles from a `pipe_key` update to the round keys being valid; minimum 0.
- OBUF_DEPTH, 32, output FIFO entries; minimum PIPE_LAT+1.
- TAG_W, 4, sideband tag width (used only with DES_CTRL_TAG_EN).
- clk  in  1  clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in/out  1/1  input block handshake.
- in_data  in  64  ciphertext block.
- key_valid / key_ready  in/out  1/1  key-load handshake.
- key_in  in  64  new key.
- pipe_data  out  64  block to pipeline input (registered).
- pipe_key  out  64  key to key schedule (registered).
- pipe_ret  in  64  pipeline result.
- out_valid / out_ready  out/in  1/1  result handshake.
- out_data  out  64  result block, FIFO head.
- busy  out  1  high when state≠RUN, or inflight≠0, or FIFO not empty.

## Operation
- FSM states:
  - NOKEY (reset state): behaves as DRAIN.
  - RUN.
  - DRAIN.
  - SETTLE.
- RUN:
  - `in_ready` = !key_valid && (inflight + fifo_count < OBUF_DEPTH).
  - On accept: `pipe_data` ← `in_data`; valid shift register bit 0 ← 1, otherwise 0.
  - key_valid → DRAIN. key_valid has priority: in_ready is low the same cycle.
- DRAIN:
  - `in_ready` = 0.
  - When inflight == 0: `key_ready` = 1 combinationally. On handshake: `pipe_key` ← `key_in`, load a KEY_LAT counter, → SETTLE.
  - If key_valid drops before the handshake, return to RUN (not from NOKEY).
- SETTLE:
  - `in_ready` = 0, `key_ready` = 0.
  - Counter decrements each cycle; → RUN when it reaches 0. With KEY_LAT = 0, go directly to RUN.
- Valid shift register, PIPE_LAT bits:
  - Shifts every cycle regardless of state.
  - When the tail bit is 1, `pipe_ret` is pushed into the FIFO at that edge.
  - inflight = popcount, kept as a separate up/down counter of width $clog2(PIPE_LAT+1).
- Output FIFO:
  - Circular buffer, OBUF_DEPTH entries; pointers wrap modulo OBUF_DEPTH.
  - The credit rule guarantees a push never meets a full FIFO.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - `out_valid` = count ≠ 0.
  - The FIFO is not flushed on key change; results already captured are delivered.
- Ordering: results leave in acceptance order.

## Timing
- Reset values: `in_ready` 0, `key_ready` 0, `out_valid` 0, `busy` 1, `pipe_data` 0, `pipe_key` 0. FIFO and shift register are cleared; state is NOKEY.
- Throughput: 1 block/cycle in RUN when out_ready is held high.
- Accept at edge N → result pushed at edge N+PIPE_LAT → `out_valid` high after edge N+PIPE_LAT. Minimum latency is PIPE_LAT+1 cycles from in_valid to out_valid.
- Key change cost: drain time + 1 handshake cycle + KEY_LAT.
- Reset mid-operation: in-flight blocks and FIFO contents are discarded, and the key must be reloaded.

## Configuration
- DES_CTRL_TAG_EN defined:
  - Adds ports `in_tag` (in, TAG_W) and `out_tag` (out, TAG_W).
  - Tag is captured on accept, carried in a PIPE_LAT-deep shift register alongside the valid bit, and stored in the FIFO with the data.
  - `out_tag` is presented together with `out_data`.
- Not defined: no tag ports and no tag storage.

## Test plan
- Reset, then in_valid=1 → in_ready=0 until key K=0x133457799BBCDFF1 is loaded. key_ready is high the first cycle after reset release; RUN follows after KEY_LAT cycles.
- Stream ciphertext 0x85E813540F0AB405 with K, out_ready=1 → out_data=0x0123456789ABCDEF exactly PIPE_LAT+1 cycles after in_valid. Back-to-back stream of 100 blocks gives 1 result/cycle, in order.
- Hold out_ready=0 → exactly OBUF_DEPTH blocks accepted, then in_ready=0, with no FIFO overflow. Release → all OBUF_DEPTH blocks emitted in order.
- Raise key_valid with 10 blocks in flight → in_ready=0 the same cycle, and key_ready rises only once inflight==0. Old-key results are correct and new-key results follow.
- key_valid and in_valid asserted in the same RUN cycle → block not accepted, state goes to DRAIN.
- Assert rst with the FIFO half full → out_valid=0 and busy=1 immediately (asynchronously). With DES_CTRL_TAG_EN, after restart tags 0..15 return on out_tag in order.

Source files
------------

// File: rtl/des_pipe_ctrl.sv
// des_pipe_ctrl: valid/ready sequencer, credit throttle and result FIFO for a
// free-running DES/TDES pipeline. Define DES_CTRL_TAG_EN for sideband tags.
module des_pipe_ctrl #(
    parameter int PIPE_LAT   = 17,
    parameter int KEY_LAT    = 1,
`ifdef DES_CTRL_TAG_EN
    parameter int TAG_W      = 4,
`endif
    parameter int OBUF_DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DES_CTRL_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [63:0]      key_in,
    output logic [63:0]      pipe_data,
    output logic [63:0]      pipe_key,
    input  logic [63:0]      pipe_ret,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy
);

    localparam int IW = $clog2(PIPE_LAT + 1);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int KW = (KEY_LAT > 0) ? $clog2(KEY_LAT + 1) : 1;
    localparam int SW = $clog2(OBUF_DEPTH + PIPE_LAT + 1);

    typedef enum logic [1:0] {
        NOKEY,
        RUN,
        DRAIN,
        SETTLE
    } state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       cnt_q, cnt_d;
    logic [63:0]         pipe_data_q, pipe_data_d;
    logic [63:0]         pipe_key_q, pipe_key_d;
    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [IW-1:0]       inflight_q, inflight_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [63:0]         mem_q [OBUF_DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic credit;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every in-flight block already owns a FIFO slot, so a push never overflows.
    assign credit = (SW'(inflight_q) + SW'(count_q)) < SW'(OBUF_DEPTH);
    assign accept = in_valid && in_ready;
    assign push   = vld_q[PIPE_LAT-1];
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pipe_key_d = pipe_key_q;
        in_ready   = 1'b0;
        key_ready  = 1'b0;
        unique case (state_q)
            RUN: begin
                in_ready = !key_valid && credit;
                if (key_valid) begin
                    state_d = DRAIN;
                end
            end
            NOKEY, DRAIN: begin
                // The key schedule is shared by all stages: wait for empty.
                key_ready = (inflight_q == '0) && !rst;
                if (key_valid && key_ready) begin
                    pipe_key_d = key_in;
                    cnt_d      = KW'(KEY_LAT);
                    state_d    = (KEY_LAT == 0) ? RUN : SETTLE;
                end else if (!key_valid && state_q == DRAIN) begin
                    state_d = RUN;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - KW'(1);
                if (cnt_q <= KW'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = NOKEY;
            end
        endcase
    end

    always_comb begin
        pipe_data_d = accept ? in_data : pipe_data_q;
        vld_d       = (vld_q << 1) | PIPE_LAT'(accept);
        inflight_d  = inflight_q + IW'(accept) - IW'(push);
        wr_ptr_d    = push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NOKEY;
            cnt_q       <= '0;
            pipe_data_q <= '0;
            pipe_key_q  <= '0;
            vld_q       <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pipe_data_q <= pipe_data_d;
            pipe_key_q  <= pipe_key_d;
            vld_q       <= vld_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pipe_ret;
        end
    end

`ifdef DES_CTRL_TAG_EN
    logic [TAG_W-1:0] tag_sr_q [PIPE_LAT];
    logic [TAG_W-1:0] tag_sr_d [PIPE_LAT];
    logic [TAG_W-1:0] tag_mem_q [OBUF_DEPTH];

    always_comb begin
        tag_sr_d[0] = accept ? in_tag : '0;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_sr_q <= '{default: '0};
        end else begin
            tag_sr_q <= tag_sr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= tag_sr_q[PIPE_LAT-1];
        end
    end

    assign out_tag = tag_mem_q[rd_ptr_q];
`endif

    assign pipe_data = pipe_data_q;
    assign pipe_key  = pipe_key_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (state_q != RUN) || (inflight_q != '0) || out_valid;

endmodule

// File: tb/tb_des_pipe_ctrl.sv
// Testbench for des_pipe_ctrl: directed table, latency/backpressure/key/reset
// sequences and random traffic against a queue-based reference model.
module tb_des_pipe_ctrl;

    localparam int PIPE_LAT   = 17;
    localparam int KEY_LAT    = 1;
    localparam int OBUF_DEPTH = 32;
    localparam int TAG_W      = 4;

    localparam logic [63:0] K1     = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] K2     = 64'h0E32_9232_EA6D_0D73;
    localparam logic [63:0] KAT_CT = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] KAT_PT = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key_in = '0;
    logic [63:0] pipe_data;
    logic [63:0] pipe_key;
    logic [63:0] pipe_ret;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;
`ifdef DES_CTRL_TAG_EN
    logic [TAG_W-1:0] in_tag = '0;
    logic [TAG_W-1:0] out_tag;
`endif

    always #5 clk = ~clk;

    des_pipe_ctrl #(
        .PIPE_LAT  (PIPE_LAT),
        .KEY_LAT   (KEY_LAT),
        .OBUF_DEPTH(OBUF_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DES_CTRL_TAG_EN
        .in_tag   (in_tag),
        .out_tag  (out_tag),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_in   (key_in),
        .pipe_data(pipe_data),
        .pipe_key (pipe_key),
        .pipe_ret (pipe_ret),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    // Stand-in cipher: the known-answer pair, otherwise a keyed mix.
    function automatic logic [63:0] cipher(input logic [63:0] d, input logic [63:0] k);
        if (d == KAT_CT && k == K1) return KAT_PT;
        return {d[31:0], d[63:32]} ^ k ^ 64'hA5A5_5A5A_C3C3_3C3C;
    endfunction

    // Pipeline mock: pipe_data register plus PIPE_LAT-1 round stages.
    logic [63:0] stage_q [PIPE_LAT-1];
    always @(posedge clk) begin
        stage_q[0] <= pipe_data;
        for (int i = 1; i < PIPE_LAT - 1; i++) stage_q[i] <= stage_q[i-1];
    end
    assign pipe_ret = cipher(stage_q[PIPE_LAT-2], pipe_key);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Reference model: outstanding blocks in acceptance order with the
    // cycle at which each result should be visible, plus the control mode.
    typedef enum {M_NOKEY, M_RUN, M_DRAIN, M_SETTLE} mode_e;
    typedef struct {
        logic [63:0]      res;
        int               avail;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    mode_e            mode = M_NOKEY;
    int               settle_left = 0;
    logic [63:0]      mkey = '0;
    logic [TAG_W-1:0] tag_ctr = '0;
    logic             seen_acc, seen_pop, seen_kr, hs;
    int               acc_cnt, pop_cnt, drain_cyc;

    task automatic step(input logic iv, input logic [63:0] d, input logic kv,
                        input logic [63:0] k, input logic ordy);
        int   n_in;
        logic e_ir, e_kr, e_ov, e_busy;
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        key_valid = kv;
        key_in    = k;
        out_ready = ordy;
`ifdef DES_CTRL_TAG_EN
        in_tag = tag_ctr;
`endif
        #1;
        n_in = 0;
        foreach (sb[i]) if (sb[i].avail > cyc) n_in++;
        e_ir   = (mode == M_RUN) && !kv && (sb.size() < OBUF_DEPTH);
        e_kr   = (mode == M_NOKEY || mode == M_DRAIN) && (n_in == 0);
        e_ov   = (sb.size() > 0) && (sb[0].avail <= cyc);
        e_busy = (mode != M_RUN) || (sb.size() != 0);
        check1("in_ready", in_ready, e_ir);
        check1("key_ready", key_ready, e_kr);
        check1("out_valid", out_valid, e_ov);
        check1("busy", busy, e_busy);
        if (e_ov) begin
            check64("out_data", out_data, sb[0].res);
`ifdef DES_CTRL_TAG_EN
            check64("out_tag", 64'(out_tag), 64'(sb[0].tag));
`endif
        end
        seen_acc = iv && in_ready;
        seen_pop = ordy && out_valid;
        seen_kr  = key_ready;
        if (seen_acc) acc_cnt++;
        if (seen_pop) pop_cnt++;
        if (e_ov && ordy) void'(sb.pop_front());
        if (iv && e_ir) begin
            e.res   = cipher(d, mkey);
            e.avail = cyc + 1 + PIPE_LAT;
            e.tag   = tag_ctr;
            sb.push_back(e);
            tag_ctr = tag_ctr + 1'b1;
        end
        hs = 1'b0;
        case (mode)
            M_RUN: if (kv) mode = M_DRAIN;
            M_NOKEY, M_DRAIN: begin
                if (kv && e_kr) begin
                    hs   = 1'b1;
                    mkey = k;
                    if (KEY_LAT == 0) mode = M_RUN;
                    else begin
                        mode        = M_SETTLE;
                        settle_left = KEY_LAT;
                    end
                end else if (!kv && mode == M_DRAIN) begin
                    mode = M_RUN;
                end
            end
            M_SETTLE: begin
                settle_left--;
                if (settle_left == 0) mode = M_RUN;
            end
            default: ;
        endcase
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((sb.size() != 0 || mode != M_RUN) && g < 400) begin
            step(1'b0, 64'h0, 1'b0, mkey, 1'b1);
            g++;
        end
        drain_cyc = g;
        n_chk++;
        if (g >= 400) begin
            n_fail++;
            $display("FAIL drain %s: model not empty after %0d cycles", name, g);
        end
    endtask

    task automatic load_key(input logic [63:0] k);
        int g = 0;
        hs = 1'b0;
        while (!hs && g < 60) begin
            step(1'b0, 64'h0, 1'b1, k, 1'b1);
            g++;
        end
        check1("key handshake", hs, 1'b1);
    endtask

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic        kv;
        logic        e_in_ready;
        logic        e_key_ready;
        logic        e_out_valid;
        logic        e_busy;
        logic [63:0] e_pipe_key;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, w, g;
        logic [63:0] kat;
        logic kv_r;

        // rst iv kv | in_ready key_ready out_valid busy | pipe_key
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, K1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, K1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, K1};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, K1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, K1};

        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            in_valid  = tbl[i].iv;
            key_valid = tbl[i].kv;
            key_in    = K1;
            in_data   = 64'hDEAD_0000_0000_0000 | 64'(i);
            #1;
            check1($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].e_in_ready);
            check1($sformatf("tbl%0d key_ready", i), key_ready, tbl[i].e_key_ready);
            check1($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].e_out_valid);
            check1($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
            check64($sformatf("tbl%0d pipe_key", i), pipe_key, tbl[i].e_pipe_key);
            check64($sformatf("tbl%0d pipe_data", i), pipe_data, 64'h0);
        end
        mode = M_RUN;
        mkey = K1;

        // Known answer and minimum latency.
        step(1'b1, KAT_CT, 1'b0, K1, 1'b1);
        lat = 0;
        kat = '0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 64'h0, 1'b0, K1, 1'b1);
            if (out_valid && lat == 0) begin
                lat = k;
                kat = out_data;
            end
        end
        check_int("kat latency", lat, PIPE_LAT + 1);
        check64("kat data", kat, KAT_PT);

        // 100 back-to-back blocks, out_ready held high.
        acc_cnt = 0;
        pop_cnt = 0;
        for (int j = 0; j < 100; j++) step(1'b1, rnd64(), 1'b0, K1, 1'b1);
        check_int("stream accepts", acc_cnt, 100);
        drain("stream");
        check_int("stream pops", pop_cnt, 100);
        check_int("stream tail cycles", drain_cyc, PIPE_LAT + 1);

        // Backpressure: exactly OBUF_DEPTH accepted, then all delivered.
        acc_cnt = 0;
        pop_cnt = 0;
        for (int j = 0; j < 60; j++) step(1'b1, rnd64(), 1'b0, K1, 1'b0);
        check_int("backpressure accepts", acc_cnt, OBUF_DEPTH);
        drain("backpressure");
        check_int("backpressure pops", pop_cnt, OBUF_DEPTH);

        // Key change with 10 blocks in flight.
        for (int j = 0; j < 10; j++) step(1'b1, rnd64(), 1'b0, K1, 1'b1);
        w = -1;
        for (int j = 0; j < 60; j++) begin
            step(1'b1, rnd64(), 1'b1, K2, 1'b1);
            if (seen_kr) begin
                w = j;
                break;
            end
        end
        check_int("key drain wait", w, PIPE_LAT);
        check64("pipe_key after change", pipe_key, K1);
        for (int j = 0; j < 12; j++) step(1'b1, rnd64(), 1'b0, K2, 1'b1);
        check64("pipe_key new", pipe_key, K2);
        drain("key change");

        // Random traffic with occasional key requests.
        for (int j = 0; j < 400; j++) begin
            kv_r = ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 3) != 0, rnd64(), kv_r,
                 ($urandom_range(0, 1) != 0) ? K1 : K2,
                 $urandom_range(0, 2) != 0);
        end
        drain("random");

        // Reset with the FIFO half full.
        for (int j = 0; j < 16; j++) step(1'b1, rnd64(), 1'b0, mkey, 1'b0);
        for (int j = 0; j < 20; j++) step(1'b0, 64'h0, 1'b0, mkey, 1'b0);
        check1("pre-reset out_valid", out_valid, 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        key_valid = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check1("rst out_valid", out_valid, 1'b0);
        check1("rst busy", busy, 1'b1);
        check1("rst in_ready", in_ready, 1'b0);
        check1("rst key_ready", key_ready, 1'b0);
        check64("rst pipe_key", pipe_key, 64'h0);
        check64("rst pipe_data", pipe_data, 64'h0);
        sb.delete();
        mode    = M_NOKEY;
        mkey    = '0;
        tag_ctr = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) step(1'b1, rnd64(), 1'b0, K1, 1'b1);
        load_key(K1);
        acc_cnt = 0;
        g = 0;
        while (acc_cnt < 16 && g < 40) begin
            step(1'b1, rnd64(), 1'b0, K1, 1'b1);
            g++;
        end
        check_int("restart accepts", acc_cnt, 16);
        drain("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
